// File: rtl/accel_resp_pkg.sv
// accel_resp_pkg: shared constants, FSM states and sample bundle
// for the accelerometer SPI responder.
package accel_resp_pkg;

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE = 6'h30;
  localparam logic [5:0] ADDR_DATAX0     = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1     = 6'h37;

  localparam logic [7:0] DEVID_VAL = 8'hE5;

  localparam int INT_DATA_READY = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_t;

  typedef struct packed {
    logic [15:0] z;
    logic [15:0] y;
    logic [15:0] x;
  } sample_t;

  function automatic logic is_axis(
    input logic [5:0] a
  );
    return (a >= ADDR_DATAX0) &&
           (a <= ADDR_DATAZ1);
  endfunction

  function automatic logic is_ro(
    input logic [5:0] a
  );
    return (a == ADDR_DEVID) ||
           (a == ADDR_INT_SOURCE) ||
           is_axis(a);
  endfunction

endpackage

// File: rtl/accel_spi_responder_spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizer with one extra
// history flop for rise/fall detection.
module spi_edge_sync
  import accel_resp_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: SPI mode-3 3-wire register responder.
// ACCEL_RESP_SHADOW_EN defers samples arriving mid-transaction.
module accel_spi_responder
  import accel_resp_pkg::*;
(
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_i,
  output logic        spi_sdat_o,
  output logic        spi_sdat_oe,
  output logic        spi_int,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);

  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_s1, cs_s2, cs_s3;
  logic       sd_s1, sd_s2;
  logic       cs_rise;
  logic       cs_fall;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [5:0] addr;
  logic       mb;
  logic       rd_axis;
  logic       data_ready;
  logic [7:0] regs [64];
  logic [7:0] rx_nxt;
  logic [5:0] addr_nxt;
  logic       byte_done;
  logic       apply;
  logic       clr;
  sample_t    new_s;
  sample_t    apply_s;

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .d_in  (spi_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // CS flops reset low so a CS held low across reset never
  // looks like a fresh falling edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cs_s1 <= 1'b0;
      cs_s2 <= 1'b0;
      cs_s3 <= 1'b0;
      sd_s1 <= 1'b0;
      sd_s2 <= 1'b0;
    end else begin
      cs_s1 <= spi_cs_n;
      cs_s2 <= cs_s1;
      cs_s3 <= cs_s2;
      sd_s1 <= spi_sdat_i;
      sd_s2 <= sd_s1;
    end
  end

  assign cs_fall   = cs_s3 & ~cs_s2;
  assign cs_rise   = ~cs_s3 & cs_s2;
  assign rx_nxt    = {rx_sh[6:0], sd_s2};
  assign addr_nxt  = mb ? addr + 6'd1 : addr;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign clr       = cs_rise && rd_axis;
  assign new_s     = '{x: sample_x, y: sample_y, z: sample_z};

  function automatic logic [7:0] rd_byte(
    input logic [5:0] a
  );
    if (a == ADDR_DEVID)
      return DEVID_VAL;
    else if (a == ADDR_INT_SOURCE)
      return 8'(data_ready) << INT_DATA_READY;
    else
      return regs[a];
  endfunction

`ifdef ACCEL_RESP_SHADOW_EN
  logic    pend;
  logic    hold;
  sample_t shadow;

  always_comb begin
    hold = sample_valid && (state != IDLE) && !cs_rise;
    apply = (sample_valid && !hold) || (cs_rise && pend);
    apply_s = sample_valid ? new_s : shadow;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend   <= 1'b0;
      shadow <= '0;
    end else if (hold) begin
      pend   <= 1'b1;
      shadow <= new_s;
    end else if (cs_rise) begin
      pend   <= 1'b0;
    end
  end
`else
  assign apply   = sample_valid;
  assign apply_s = new_s;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_sh       <= 8'h00;
      tx_sh       <= 8'h00;
      addr        <= 6'd0;
      mb          <= 1'b0;
      rd_axis     <= 1'b0;
      spi_sdat_o  <= 1'b0;
      spi_sdat_oe <= 1'b0;
    end else if (cs_rise) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rd_axis     <= 1'b0;
      spi_sdat_o  <= 1'b0;
      spi_sdat_oe <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= 3'd0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_sh   <= rx_nxt;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done) begin
            addr  <= rx_nxt[5:0];
            mb    <= rx_nxt[6];
            tx_sh <= rd_byte(rx_nxt[5:0]);
            state <= rx_nxt[7] ? RD_DATA : WR_DATA;
          end
        end
        WR_DATA: begin
          if (sclk_rise) begin
            rx_sh   <= rx_nxt;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done)
            addr <= addr_nxt;
        end
        RD_DATA: begin
          if (sclk_fall) begin
            spi_sdat_oe <= 1'b1;
            spi_sdat_o  <= tx_sh[7];
            tx_sh       <= {tx_sh[6:0], 1'b0};
          end
          if (sclk_rise)
            bit_cnt <= bit_cnt + 3'd1;
          // Prefetch the next byte once the current one is done.
          if (byte_done) begin
            rd_axis <= rd_axis | is_axis(addr);
            addr    <= addr_nxt;
            tx_sh   <= rd_byte(addr_nxt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++)
        regs[i] <= 8'h00;
      data_ready <= 1'b0;
      spi_int    <= 1'b0;
    end else begin
      if ((state == WR_DATA) && byte_done &&
          !cs_rise && !is_ro(addr))
        regs[addr] <= rx_nxt;
      if (apply) begin
        regs[ADDR_DATAX0]       <= apply_s.x[7:0];
        regs[ADDR_DATAX0+6'd1]  <= apply_s.x[15:8];
        regs[ADDR_DATAX0+6'd2]  <= apply_s.y[7:0];
        regs[ADDR_DATAX0+6'd3]  <= apply_s.y[15:8];
        regs[ADDR_DATAX0+6'd4]  <= apply_s.z[7:0];
        regs[ADDR_DATAX0+6'd5]  <= apply_s.z[15:8];
      end
      if (apply)
        data_ready <= 1'b1;
      else if (clr)
        data_ready <= 1'b0;
      spi_int <= data_ready &
                 regs[ADDR_INT_ENABLE][INT_DATA_READY];
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb_accel_spi_responder: bit-banged SPI mode-3 master with
// a byte scoreboard for the accelerometer responder.
module tb_accel_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        cs_n = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        oe;
  logic        intr;
  logic        sv = 1'b0;
  logic [15:0] sx = '0;
  logic [15:0] sy = '0;
  logic [15:0] sz = '0;

  logic [15:0] nx, ny, nz;
  logic [7:0]  exp_q [$];
  logic [7:0]  rd_buf [8];
  logic [7:0]  e;
  logic        oe_cmd;
  logic        oe_dat;
  logic        oe_end;
  logic        int_pre;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  accel_spi_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .spi_sclk      (sclk),
    .spi_cs_n      (cs_n),
    .spi_sdat_i    (sdi),
    .spi_sdat_o    (sdo),
    .spi_sdat_oe   (oe),
    .spi_int       (intr),
    .sample_valid  (sv),
    .sample_x      (sx),
    .sample_y      (sy),
    .sample_z      (sz)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_sample();
    sv = 1'b1;
    sx = nx;
    sy = ny;
    sz = nz;
    wait_cyc(1);
    sv = 1'b0;
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_cyc(8);
  endtask

  task automatic cs_end();
    wait_cyc(8);
    int_pre = intr;
    cs_n = 1'b1;
    wait_cyc(4);
    oe_end = oe;
    wait_cyc(12);
  endtask

  task automatic spi_wr(input logic [7:0] b,
                        output logic oe_any);
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      sdi = b[i];
      wait_cyc(8);
      oe_any = oe_any | oe;
      sclk = 1'b1;
      wait_cyc(8);
    end
  endtask

  task automatic spi_rd(output logic [7:0] b,
                        output logic oe_all,
                        input int pulse_bit);
    oe_all = 1'b1;
    b = '0;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      sdi = 1'b0;
      if (i == pulse_bit) begin
        wait_cyc(7);
        do_sample();
      end else begin
        wait_cyc(8);
      end
      b[i] = sdo;
      oe_all = oe_all & oe;
      sclk = 1'b1;
      wait_cyc(8);
    end
  endtask

  task automatic rd_txn(input logic [7:0] cmd,
                        input int n,
                        input int pb_byte,
                        input int pb_bit);
    logic o;
    cs_begin();
    spi_wr(cmd, oe_cmd);
    oe_dat = 1'b1;
    for (int k = 0; k < n; k++) begin
      spi_rd(rd_buf[k], o,
             (k == pb_byte) ? pb_bit : -1);
      oe_dat = oe_dat & o;
    end
    cs_end();
  endtask

  task automatic wr_reg(input logic [5:0] a,
                        input logic [7:0] d);
    logic o;
    cs_begin();
    spi_wr({2'b00, a}, o);
    spi_wr(d, o);
    cs_end();
  endtask

  task automatic test_reset();
    wait_cyc(3);
    n_chk++;
    if (oe !== 1'b0)
      $display("FAIL rst_oe: got %b want 0", oe);
    else n_pass++;
    n_chk++;
    if (sdo !== 1'b0)
      $display("FAIL rst_sdo: got %b want 0", sdo);
    else n_pass++;
    n_chk++;
    if (intr !== 1'b0)
      $display("FAIL rst_int: got %b want 0", intr);
    else n_pass++;
    rst_n = 1'b1;
    wait_cyc(10);
  endtask

  task automatic test_devid();
    exp_q.push_back(8'hE5);
    rd_txn(8'h80, 1, -1, -1);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_buf[0] !== e)
      $display("FAIL devid: got %h want %h", rd_buf[0], e);
    else n_pass++;
    n_chk++;
    if (oe_cmd !== 1'b0)
      $display("FAIL oe_cmd: got %b want 0", oe_cmd);
    else n_pass++;
    n_chk++;
    if (oe_dat !== 1'b1)
      $display("FAIL oe_data: got %b want 1", oe_dat);
    else n_pass++;
    n_chk++;
    if (oe_end !== 1'b0)
      $display("FAIL oe_end: got %b want 0", oe_end);
    else n_pass++;
  endtask

  task automatic test_int();
    wr_reg(6'h2E, 8'h80);
    exp_q.push_back(8'h80);
    rd_txn(8'hAE, 1, -1, -1);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_buf[0] !== e)
      $display("FAIL int_en_rd: got %h want %h", rd_buf[0], e);
    else n_pass++;
    nx = 16'h1234;
    ny = 16'hFFFE;
    nz = 16'h0100;
    do_sample();
    n_chk++;
    if (intr !== 1'b0)
      $display("FAIL int_lat0: got %b want 0", intr);
    else n_pass++;
    wait_cyc(1);
    n_chk++;
    if (intr !== 1'b1)
      $display("FAIL int_lat1: got %b want 1", intr);
    else n_pass++;
  endtask

  task automatic test_burst();
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    rd_txn(8'hF2, 6, -1, -1);
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_buf[k] !== e)
        $display("FAIL burst b%0d: got %h want %h", k, rd_buf[k], e);
      else n_pass++;
    end
    n_chk++;
    if (int_pre !== 1'b1)
      $display("FAIL burst_int_pre: got %b want 1", int_pre);
    else n_pass++;
    n_chk++;
    if (intr !== 1'b0)
      $display("FAIL burst_int_clr: got %b want 0", intr);
    else n_pass++;
    exp_q.push_back(8'h00);
    rd_txn(8'hB0, 1, -1, -1);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_buf[0] !== e)
      $display("FAIL int_src: got %h want %h", rd_buf[0], e);
    else n_pass++;
  endtask

  task automatic test_single_addr();
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h34);
    rd_txn(8'hB2, 2, -1, -1);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_buf[k] !== e)
        $display("FAIL mb0 b%0d: got %h want %h", k, rd_buf[k], e);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hE5);
    rd_txn(8'hFF, 2, -1, -1);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_buf[k] !== e)
        $display("FAIL wrap b%0d: got %h want %h", k, rd_buf[k], e);
      else n_pass++;
    end
  endtask

  task automatic test_partial();
    logic o;
    cs_begin();
    spi_wr(8'h2E, o);
    for (int i = 7; i >= 4; i--) begin
      sclk = 1'b0;
      sdi = 1'b0;
      wait_cyc(8);
      sclk = 1'b1;
      wait_cyc(8);
    end
    cs_end();
    wr_reg(6'h00, 8'h12);
    exp_q.push_back(8'h80);
    rd_txn(8'hAE, 1, -1, -1);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_buf[0] !== e)
      $display("FAIL partial: got %h want %h", rd_buf[0], e);
    else n_pass++;
    exp_q.push_back(8'hE5);
    rd_txn(8'h80, 1, -1, -1);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_buf[0] !== e)
      $display("FAIL ro_wr: got %h want %h", rd_buf[0], e);
    else n_pass++;
  endtask

  task automatic test_midburst();
    nx = 16'h1111;
    ny = 16'h2222;
    nz = 16'h3333;
    do_sample();
    wait_cyc(4);
    nx = 16'hAAAA;
    ny = 16'hBBBB;
    nz = 16'hCCCC;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
`ifdef ACCEL_RESP_SHADOW_EN
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h33);
`else
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'hCC);
`endif
    rd_txn(8'hF2, 6, 1, 3);
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_buf[k] !== e)
        $display("FAIL mid b%0d: got %h want %h", k, rd_buf[k], e);
      else n_pass++;
    end
`ifdef ACCEL_RESP_SHADOW_EN
    e = 8'h01;
`else
    e = 8'h00;
`endif
    n_chk++;
    if (intr !== e[0])
      $display("FAIL mid_int: got %b want %b", intr, e[0]);
    else n_pass++;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'hCC);
    rd_txn(8'hF2, 6, -1, -1);
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_buf[k] !== e)
        $display("FAIL post b%0d: got %h want %h", k, rd_buf[k], e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic o;
    cs_begin();
    spi_wr(8'h2E, o);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    n_chk++;
    if (oe !== 1'b0)
      $display("FAIL abort_oe: got %b want 0", oe);
    else n_pass++;
    spi_wr(8'h2E, o);
    spi_wr(8'h80, o);
    cs_end();
    exp_q.push_back(8'h00);
    rd_txn(8'hAE, 1, -1, -1);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_buf[0] !== e)
      $display("FAIL abort_reg: got %h want %h", rd_buf[0], e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_devid();
    test_int();
    test_burst();
    test_single_addr();
    test_wrap();
    test_partial();
    test_midburst();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 SHALL have port clk_clk, input, 1, single system clock; every flop in the block is on it.
REQ-002 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port spi_sclk, input, 1, serial clock from the accelerometer SPI initiator, idle high.
REQ-004 SHALL have port spi_cs_n, input, 1, chip select, active low.
REQ-005 SHALL have port spi_sdat_i, input, 1, 3-wire data line as sampled from the pad.
REQ-006 SHALL have port spi_sdat_o, output, 1, data driven onto the line during reads.
REQ-007 SHALL have port spi_sdat_oe, output, 1, pad output enable for spi_sdat_o.
REQ-008 SHALL have port spi_int, output, 1, G_SENSOR_INT equivalent, active high.
REQ-009 SHALL have port sample_valid, input, 1, one-cycle strobe that a new X/Y/Z sample is present.
REQ-010 SHALL have ports sample_x, sample_y, sample_z, input, 16 each, two's-complement axis data.

Function
REQ-011 SHALL pass spi_sclk, spi_cs_n and spi_sdat_i through 2-flop synchronizers, then detect SCLK rise/fall; clk_clk is at least 8x SCLK.
REQ-012 SHALL implement SPI mode 3: sample spi_sdat_i on detected SCLK rise, change spi_sdat_o on detected SCLK fall, MSB first.
REQ-013 SHALL treat the first byte after CS fall as the command: bit7 R/W (1 = read), bit6 MB (multibyte), bits5:0 address.
REQ-014 SHALL use FSM states IDLE, CMD, WR_DATA, RD_DATA: IDLE->CMD on CS fall; CMD->RD_DATA or WR_DATA after the 8th rise; any state->IDLE on CS rise.
REQ-015 SHALL hold a 64 x 8 register file.
REQ-016 SHALL return 0xE5 at 0x00 (DEVID, read-only).
REQ-017 SHALL map 0x2E as INT_ENABLE (bit7 = DATA_READY enable), 0x30 as INT_SOURCE (read-only, bit7 = DATA_READY), and 0x32..0x37 as X0,X1,Y0,Y1,Z0,Z1 (read-only, little-endian).
REQ-018 SHALL commit a write byte only after its 8th rise; writes to read-only addresses are discarded.
REQ-019 SHALL, in RD_DATA, assert spi_sdat_oe and present the data MSB within 3 clk_clk cycles of the first SCLK fall after the command byte.
REQ-020 SHALL deassert spi_sdat_oe within 3 cycles of CS rise.
REQ-021 SHALL, with MB=1, increment the address after each byte; 0x3F wraps to 0x00.
REQ-022 SHALL, with MB=0, repeat the same address.
REQ-023 SHALL discard a partial byte on CS rise mid-byte and return to IDLE with no register change.
REQ-024 SHALL on sample_valid load 0x32..0x37 and set DATA_READY.
REQ-025 SHALL clear DATA_READY when a transaction reading any of 0x32..0x37 ends (CS rise).
REQ-026 SHALL let sample_valid win over the clear when both occur in the same cycle.
REQ-027 SHALL drive spi_int = DATA_READY AND INT_ENABLE[7], registered (1 cycle latency).

Reset
REQ-028 SHALL, on reset_reset_n low, immediately force spi_sdat_o=0, spi_sdat_oe=0, spi_int=0, FSM=IDLE, all registers 0x00 except DEVID, and DATA_READY=0.
REQ-029 SHALL make reset during a transaction abort it; the bus is ignored until the next CS fall after reset release.

Configuration
REQ-030 SHALL, with ACCEL_RESP_SHADOW_EN defined, hold a sample_valid arriving while CS is low in a shadow register and apply it (data + DATA_READY) on CS rise, giving coherent burst reads.
REQ-031 SHALL, without ACCEL_RESP_SHADOW_EN, apply sample_valid immediately regardless of CS.

Structure
REQ-032 SHALL put address constants, the DEVID value, the FSM state enum and the INT bit positions in shared package accel_resp_pkg.
REQ-033 SHALL use one sub-module, spi_edge_sync (synchronizer plus rise/fall detect), instantiated for SCLK, with CS and SDAT synchronized alongside.

Verification
REQ-034 Bench SHALL check: read of 0x00 (cmd 0x80) -> 0xE5 shifted out, spi_sdat_oe high only during the data byte.
REQ-035 Bench SHALL check: write 0x80 to 0x2E then sample_valid with x=0x1234 -> spi_int rises 1 cycle after DATA_READY sets.
REQ-036 Bench SHALL check: MB read from 0x32 of 6 bytes (cmd 0xF2) after x=0x1234, y=0xFFFE, z=0x0100 -> 34 12 FE FF 00 01; DATA_READY and spi_int clear at CS rise.
REQ-037 Bench SHALL check: MB read starting at 0x3F for 2 bytes -> second byte is 0xE5 (wrap).
REQ-038 Bench SHALL check: write cmd to 0x2E, CS rise after 4 data bits -> 0x2E unchanged.
REQ-039 Bench SHALL check: sample_valid mid burst read -> old data completes and new data appears at CS rise with macro; new data visible immediately without it.
